uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Control and buffering block for the 5x-oversampling UART receiver. It owns the receiver's enable and oversample-divider inputs, and sequences a clean re-arm whenever software enables the receiver or changes the baud rate. It captures received bytes into a small show-ahead FIFO with overrun flagging, and raises an idle-line timeout after a burst of bytes ends. It sits between the register/host interface and the receiver instance.

## Interface
Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (8).
- IDLE_BITS, 20, idle timeout in bit-times; the timeout fires after 5*IDLE_BITS sample ticks.
- DIV_RST, 10'd216, reset value of the oversample divider; the sample period is DIV_RST+1 clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high; all state clears immediately.
- rx_enable  in  1  software receive enable (level).
- cfg_wr  in  1  one-cycle strobe that loads cfg_div.
- cfg_div  in  10  new oversample count; the sample period is cfg_div+1 clocks.
- rx_en  out  1  enable to the receiver.
- over_sample_clk_cnt  out  10  divider to the receiver; always equals the divider register.
- rx_byte  in  8  received byte from the receiver.
- rx_byte_dv  in  1  one-cycle valid from the receiver.
- rd_en  in  1  pop request; honoured only while rd_valid=1.
- rd_data  out  8  FIFO head (show-ahead).
- rd_valid  out  1  FIFO non-empty.
- fifo_count  out  DEPTH_LOG2+1  occupancy, 0..8.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- clr_overrun  in  1  clears overrun.
- idle_timeout  out  1  one-cycle pulse at the end of a received burst.

## Operation
State machine with three states: OFF, ARM, RUN.
- OFF: rx_en=0.
  - Goes to ARM when rx_enable=1.
- ARM: rx_en=0 for exactly 2 cycles, counted by an arm counter, then goes to RUN.
  - If rx_enable=0 during ARM, go to OFF.
- RUN: rx_en=1.
  - Goes to OFF when rx_enable=0.
  - Goes to ARM, restarting the 2-cycle count, on cfg_wr.
- cfg_wr is accepted in any state. The divider register updates at that edge.
  - A cfg_wr while in ARM restarts the 2-cycle count.
  - The net effect is that rx_en always rises at least 2 cycles after the last divider change. The receiver therefore reloads its counter with the new value.

FIFO:
- Write when rx_byte_dv=1 and state=RUN. rx_byte_dv outside RUN is ignored.
- Write while full: the byte is dropped and overrun is set.
  - Exception: if rd_en pops in the same cycle, the write is accepted and the count is unchanged.
- Read (rd_en=1) while empty is ignored. No underflow and no pointer movement.
- Read and write together while non-empty: both occur and the count is unchanged.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally. fifo_count tracks occupancy separately.
- Contents persist across OFF/ARM; only rst flushes the FIFO.

overrun:
- clr_overrun clears overrun.
- If a set event and clr_overrun occur in the same cycle, set wins.

Idle timer:
- An internal tick counter reloads with the divider value and counts down. It issues one tick per cfg_div+1 clocks while in RUN, and is held at reload outside RUN.
- The idle counter clears on every accepted or dropped rx_byte_dv, and otherwise counts ticks, saturating.
- idle_timeout pulses once when the idle counter reaches 5*IDLE_BITS, and only if at least one byte has arrived since the previous pulse (armed flag).
- Leaving RUN clears the armed flag and the idle counter.

## Timing
- Reset values:
  - State OFF, rx_en=0, over_sample_clk_cnt=DIV_RST.
  - rd_valid=0, rd_data=0, fifo_count=0.
  - overrun=0, idle_timeout=0, all pointers and counters 0.
- rx_enable rising at edge N: ARM at N+1, rx_en=1 at N+3.
- A byte written at edge N gives rd_valid=1 and updated rd_data/fifo_count after N (1-cycle latency).
- Pop at edge N: the next head appears after N.
- All outputs are registered except rd_data and rd_valid, which are decoded from registered FIFO state.
- over_sample_clk_cnt changes on the edge following cfg_wr. rx_en is already low at that point, or drops on the same edge.

## Structure
- Shared package uart_pkg holds:
  - the state encoding (OFF=2'd0, ARM=2'd1, RUN=2'd2);
  - SAMPLES_PER_BIT=5;
  - the default divider value;
  - ARM_CYCLES=2.
- Sub-module uart_rx_fifo contains the storage, pointers, count and full/empty logic. It has push and pop ports and a push_drop output.
- The control FSM, tick counter, idle logic and overrun flag stay in the top level.

## Test plan
- Enable after reset: rx_enable=1 at cycle 5 -> rx_en=1 at cycle 8; over_sample_clk_cnt=216 throughout.
- Baud change in RUN: cfg_wr with cfg_div=42 -> rx_en low for exactly 2 cycles, divider=42 one edge after the strobe, then rx_en high again.
- Fill and overrun: push 9 bytes 0x01..0x09 with no reads -> fifo_count=8 and overrun=1. Then pop 8 -> data 0x01..0x08, rd_valid=0.
- Full boundary: FIFO full, rd_en and rx_byte_dv (0xA5) in the same cycle -> count stays 8, overrun stays 0, last entry 0xA5.
- Idle timeout: cfg_div=3, IDLE_BITS=20; one byte, then silence -> single idle_timeout pulse 400 clocks after the byte; no second pulse without a new byte.
- Async reset in RUN with 3 bytes queued -> all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive control block.
package uart_pkg;

  // Control state encoding
  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2
  } rx_state_t;

  // Receiver oversampling ratio
  localparam int SAMPLES_PER_BIT = 5;

  // Divider value loaded at reset
  localparam logic [9:0] DIV_DEFAULT = 10'd216;

  // Number of cycles rx_en stays low while re-arming
  localparam int ARM_CYCLES = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO with separate occupancy count.
// A push into a full FIFO is dropped (push_drop) unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  push_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  empty;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && full && !do_pop;

  assign count    = count_q;
  assign rd_valid = !empty;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents are only visible through the count-gated head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive control: enable/re-arm sequencing, divider register, byte FIFO,
// sticky overrun and idle-line timeout detection.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 3,
  parameter int         IDLE_BITS  = 20,
  parameter logic [9:0] DIV_RST    = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_enable,
  input  logic                  cfg_wr,
  input  logic [9:0]            cfg_div,
  output logic                  rx_en,
  output logic [9:0]            over_sample_clk_cnt,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_byte_dv,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overrun,
  input  logic                  clr_overrun,
  output logic                  idle_timeout
);

  localparam int         IDLE_LIMIT = SAMPLES_PER_BIT * IDLE_BITS;
  localparam int         IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic [1:0] ARM_LAST   = 2'(ARM_CYCLES - 1);

  rx_state_t         state;
  rx_state_t         state_next;
  logic [1:0]        arm_cnt;
  logic [1:0]        arm_cnt_next;
  logic [9:0]        div_q;
  logic [9:0]        tick_cnt;
  logic              tick;
  logic              push;
  logic              push_drop;
  logic [IDLE_W-1:0] idle_cnt;
  logic              armed;

  assign over_sample_clk_cnt = div_q;
  assign push = rx_byte_dv && (state == RUN);
  assign tick = (state == RUN) && (tick_cnt == '0);

  // Next-state logic: any divider write restarts the arm count so the
  // receiver is only enabled once the new divider has settled
  always_comb begin
    state_next   = state;
    arm_cnt_next = arm_cnt;
    case (state)
      OFF: begin
        if (rx_enable) begin
          state_next   = ARM;
          arm_cnt_next = '0;
        end
      end
      ARM: begin
        if (!rx_enable) begin
          state_next = OFF;
        end else if (cfg_wr) begin
          arm_cnt_next = '0;
        end else if (arm_cnt == ARM_LAST) begin
          state_next = RUN;
        end else begin
          arm_cnt_next = arm_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!rx_enable) begin
          state_next = OFF;
        end else if (cfg_wr) begin
          state_next   = ARM;
          arm_cnt_next = '0;
        end
      end
      default: begin
        state_next   = OFF;
        arm_cnt_next = '0;
      end
    endcase
  end

  // State register, registered enable and divider register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      arm_cnt <= '0;
      rx_en   <= 1'b0;
      div_q   <= DIV_RST;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_cnt_next;
      rx_en   <= (state_next == RUN);
      if (cfg_wr) div_q <= cfg_div;
    end
  end

  // Sample-tick generator: one tick every div_q+1 clocks while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= DIV_RST;
    end else if (state != RUN || tick_cnt == '0) begin
      tick_cnt <= div_q;
    end else begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  // Idle-line detection: a single pulse per burst, re-armed by any received byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt     <= '0;
      armed        <= 1'b0;
      idle_timeout <= 1'b0;
    end else begin
      idle_timeout <= 1'b0;
      if (state != RUN) begin
        idle_cnt <= '0;
        armed    <= 1'b0;
      end else if (push) begin
        idle_cnt <= '0;
        armed    <= 1'b1;
      end else if (tick && idle_cnt != IDLE_W'(IDLE_LIMIT)) begin
        idle_cnt <= idle_cnt + 1'b1;
        if (armed && idle_cnt == IDLE_W'(IDLE_LIMIT - 1)) begin
          idle_timeout <= 1'b1;
          armed        <= 1'b0;
        end
      end
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (push_drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rx_byte),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (fifo_count),
    .push_drop (push_drop)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a queue-based scoreboard on FIFO pops.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_enable = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [9:0] cfg_div = '0;
  logic       rx_en;
  logic [9:0] over_sample_clk_cnt;
  logic [7:0] rx_byte = '0;
  logic       rx_byte_dv = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       idle_timeout;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_enable           (rx_enable),
    .cfg_wr              (cfg_wr),
    .cfg_div             (cfg_div),
    .rx_en               (rx_en),
    .over_sample_clk_cnt (over_sample_clk_cnt),
    .rx_byte             (rx_byte),
    .rx_byte_dv          (rx_byte_dv),
    .rd_en               (rd_en),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .fifo_count          (fifo_count),
    .overrun             (overrun),
    .clr_overrun         (clr_overrun),
    .idle_timeout        (idle_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] b, input logic rd, input logic clr);
    rx_byte_dv  = dv;
    rx_byte     = b;
    rd_en       = rd;
    clr_overrun = clr;
    step();
    rx_byte_dv  = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
  endtask

  // Scoreboard monitor: every honoured pop is compared against the expected queue head
  always @(negedge clk) begin
    if (!rst && rd_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL pop_unexpected: got=%0h want=none", rd_data);
      end else begin
        checkOutput("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    int pulses;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_rx_en",   32'(rx_en), 32'd0);
    checkOutput("rst_div",     32'(over_sample_clk_cnt), 32'd216);
    checkOutput("rst_rd_valid",32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_count",   32'(fifo_count), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_idle",    32'(idle_timeout), 32'd0);

    $display("[TB] enable sequencing");
    step(); step();
    rx_enable = 1'b1;
    step();
    checkOutput("en_arm1", 32'(rx_en), 32'd0);
    step();
    checkOutput("en_arm2", 32'(rx_en), 32'd0);
    step();
    checkOutput("en_run", 32'(rx_en), 32'd1);
    checkOutput("en_div", 32'(over_sample_clk_cnt), 32'd216);

    $display("[TB] baud change in RUN");
    cfg_div = 10'd42;
    cfg_wr  = 1'b1;
    step();
    cfg_wr  = 1'b0;
    checkOutput("baud_rx_en0", 32'(rx_en), 32'd0);
    checkOutput("baud_div",    32'(over_sample_clk_cnt), 32'd42);
    step();
    checkOutput("baud_rx_en1", 32'(rx_en), 32'd0);
    step();
    checkOutput("baud_rx_en2", 32'(rx_en), 32'd1);

    $display("[TB] fill and overrun");
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    end
    checkOutput("fill_count",   32'(fifo_count), 32'd8);
    checkOutput("fill_overrun", 32'(overrun), 32'd1);
    checkOutput("fill_head",    32'(rd_data), 32'h01);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("drain_valid", 32'(rd_valid), 32'd0);
    checkOutput("drain_count", 32'(fifo_count), 32'd0);
    checkOutput("drain_data",  32'(rd_data), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("empty_pop_count", 32'(fifo_count), 32'd0);
    checkOutput("overrun_sticky",  32'(overrun), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("overrun_clr", 32'(overrun), 32'd0);

    $display("[TB] full boundary");
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    end
    checkOutput("full_count", 32'(fifo_count), 32'd8);
    exp_q.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    checkOutput("rdwr_full_count",   32'(fifo_count), 32'd8);
    checkOutput("rdwr_full_overrun", 32'(overrun), 32'd0);
    checkOutput("rdwr_full_head",    32'(rd_data), 32'h11);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    checkOutput("set_wins_overrun", 32'(overrun), 32'd1);
    checkOutput("set_wins_count",   32'(fifo_count), 32'd8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("full_drain_valid", 32'(rd_valid), 32'd0);

    $display("[TB] bytes outside RUN");
    rx_enable = 1'b0;
    step();
    checkOutput("off_rx_en", 32'(rx_en), 32'd0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("off_count", 32'(fifo_count), 32'd0);

    $display("[TB] idle timeout");
    cfg_div   = 10'd3;
    cfg_wr    = 1'b1;
    rx_enable = 1'b1;
    step();
    cfg_wr = 1'b0;
    step(); step();
    checkOutput("idle_run",  32'(rx_en), 32'd1);
    checkOutput("idle_div",  32'(over_sample_clk_cnt), 32'd3);
    exp_q.push_back(8'h5A);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 600) begin
      step();
      n++;
      if (idle_timeout) seen = 1'b1;
    end
    checkOutput("idle_seen", 32'(seen), 32'd1);
    if (!(n >= 397 && n <= 400)) $display("[TB] idle pulse seen %0d clocks after byte", n);
    checkOutput("idle_delay_in_window", 32'(n >= 397 && n <= 400), 32'd1);
    step();
    checkOutput("idle_one_cycle", 32'(idle_timeout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (idle_timeout) pulses++;
    end
    checkOutput("idle_no_second", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] async reset in RUN");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'h30 + i));
      applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    end
    checkOutput("pre_rst_count", 32'(fifo_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("arst_rx_en",   32'(rx_en), 32'd0);
    checkOutput("arst_div",     32'(over_sample_clk_cnt), 32'd216);
    checkOutput("arst_valid",   32'(rd_valid), 32'd0);
    checkOutput("arst_data",    32'(rd_data), 32'd0);
    checkOutput("arst_count",   32'(fifo_count), 32'd0);
    checkOutput("arst_overrun", 32'(overrun), 32'd0);
    checkOutput("arst_idle",    32'(idle_timeout), 32'd0);
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
